// File: rtl/miriscv_lsu.sv
// miriscv_lsu: load/store unit with a single outstanding data-bus transaction.
// It accepts one LOAD/STORE from execute, drives a word-aligned bus request
// with byte enables and replicated store data, waits for the response, and
// returns sign- or zero-extended load data. Misaligned and illegal requests
// never reach the bus.
//
// Ports:
//   clk_i, rst_i        core clock, asynchronous active-high reset
//   lsu_req_i/we_i/size_i/addr_i/wdata_i/kill_i   request from execute
//   lsu_rdata_o         extended load result (held until the next load)
//   lsu_stall_o         pipeline stall while a transaction is in flight
//   lsu_misaligned_o    misaligned flag for the current request
//   data_*              data bus (req/gnt address phase, rvalid response)
module miriscv_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_size_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  input  logic            lsu_kill_i,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_stall_o,
  output logic            lsu_misaligned_o,
  output logic            data_req_o,
  output logic            data_we_o,
  output logic [3:0]      data_be_o,
  output logic [XLEN-1:0] data_addr_o,
  output logic [XLEN-1:0] data_wdata_o,
  input  logic            data_gnt_i,
  input  logic            data_rvalid_i,
  input  logic [XLEN-1:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state_q;
  logic            req_q, we_q, discard_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]      size_q;
  logic [1:0]      off_q;

  logic            size_legal, misal, accept;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d, rdata_d;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  // Unsigned sizes (1xx) exist for loads only.
  always_comb begin
    size_legal = 1'b0;
    case (lsu_size_i)
      3'b000, 3'b001, 3'b010: size_legal = 1'b1;
      3'b100, 3'b101:         size_legal = !lsu_we_i;
      default:                size_legal = 1'b0;
    endcase
  end

  assign misal = ((lsu_size_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                 ((lsu_size_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));

  assign accept = (state_q == IDLE) && lsu_req_i && size_legal && !misal && !lsu_kill_i;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = lsu_wdata_i;
    case (lsu_size_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << lsu_addr_i[1:0];
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = lsu_wdata_i;
      end
    endcase
  end

  // Lane extraction uses the offset captured at accept, not the live address.
  always_comb begin
    byte_sel = data_rdata_i[7:0];
    case (off_q)
      2'd0:    byte_sel = data_rdata_i[7:0];
      2'd1:    byte_sel = data_rdata_i[15:8];
      2'd2:    byte_sel = data_rdata_i[23:16];
      default: byte_sel = data_rdata_i[31:24];
    endcase
    half_sel = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q)
      3'b000:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  rdata_d = {24'd0, byte_sel};
      3'b001:  rdata_d = {{16{half_sel[15]}}, half_sel};
      3'b101:  rdata_d = {16'd0, half_sel};
      default: rdata_d = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      size_q    <= 3'd0;
      off_q     <= 2'd0;
      discard_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            req_q     <= 1'b1;
            we_q      <= lsu_we_i;
            be_q      <= be_d;
            addr_q    <= {lsu_addr_i[XLEN-1:2], 2'b00};
            wdata_q   <= wdata_d;
            size_q    <= lsu_size_i;
            off_q     <= lsu_addr_i[1:0];
            discard_q <= 1'b0;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            // Once granted the response must still be consumed, even if killed.
            req_q     <= 1'b0;
            discard_q <= lsu_kill_i;
            state_q   <= RESP;
          end else if (lsu_kill_i) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        RESP: begin
          if (data_rvalid_i) begin
            if (discard_q || lsu_kill_i) begin
              state_q <= IDLE;
            end else begin
              if (!we_q) rdata_q <= rdata_d;
              state_q <= DONE;
            end
          end else if (lsu_kill_i) begin
            discard_q <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  // Reset gates the combinational flags so every output is 0 during reset.
  assign lsu_stall_o = !rst_i && !lsu_kill_i &&
                       (accept || (state_q == REQ) || (state_q == RESP));
  assign lsu_misaligned_o = !rst_i && (state_q == IDLE) && lsu_req_i && size_legal && misal;

  assign lsu_rdata_o  = rdata_q;
  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, lsu_kill_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_stall_o, lsu_misaligned_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;

  miriscv_lsu #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_kill_i(lsu_kill_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_stall_o(lsu_stall_o),
    .lsu_misaligned_o(lsu_misaligned_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_rd = 32'd0;

  localparam int K_OK = 0, K_MIS = 1, K_ILL = 2;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          kind;
    logic [3:0]  be;
    logic [31:0] wd_exp;
    logic [31:0] rd_exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 3'b010; lsu_addr_i = 0;
    lsu_wdata_i = 0; lsu_kill_i = 0; data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
  endtask

  task automatic start(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge clk_i);
    lsu_req_i = 1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_wdata_i = wdata;
    data_gnt_i = 0; data_rvalid_i = 0;
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_rd;
    start(v.we, v.size, v.addr, v.wdata);
    chk({v.name, " misaligned"}, {31'd0, lsu_misaligned_o}, {31'd0, v.kind == K_MIS});
    if (v.kind != K_OK) begin
      chk({v.name, " stall"}, {31'd0, lsu_stall_o}, 32'd0);
      @(negedge clk_i); #1;
      chk({v.name, " no bus req"}, {31'd0, data_req_o}, 32'd0);
      chk({v.name, " still no stall"}, {31'd0, lsu_stall_o}, 32'd0);
      lsu_req_i = 0;
      $display("txn %s addr=0x%08h rejected kind=%0d", v.name, v.addr, v.kind);
      return;
    end
    chk({v.name, " stall c0"}, {31'd0, lsu_stall_o}, 32'd1);
    @(negedge clk_i); #1;
    chk({v.name, " req c1"}, {31'd0, data_req_o}, 32'd1);
    chk({v.name, " stall c1"}, {31'd0, lsu_stall_o}, 32'd1);
    chk({v.name, " addr"}, data_addr_o, {v.addr[31:2], 2'b00});
    chk({v.name, " be"}, {28'd0, data_be_o}, {28'd0, v.be});
    chk({v.name, " we"}, {31'd0, data_we_o}, {31'd0, v.we});
    if (v.we) chk({v.name, " wdata"}, data_wdata_o, v.wd_exp);
    data_gnt_i = 1;
    @(negedge clk_i);
    data_gnt_i = 0; #1;
    chk({v.name, " req drop c2"}, {31'd0, data_req_o}, 32'd0);
    chk({v.name, " stall c2"}, {31'd0, lsu_stall_o}, 32'd1);
    data_rvalid_i = 1; data_rdata_i = v.rdata;
    @(negedge clk_i);
    data_rvalid_i = 0; #1;
    exp_rd = v.we ? last_rd : v.rd_exp;
    chk({v.name, " stall done"}, {31'd0, lsu_stall_o}, 32'd0);
    chk({v.name, " rdata"}, lsu_rdata_o, exp_rd);
    last_rd = exp_rd;
    lsu_req_i = 0;
    @(negedge clk_i); #1;
    chk({v.name, " idle stall"}, {31'd0, lsu_stall_o}, 32'd0);
    chk({v.name, " idle req"}, {31'd0, data_req_o}, 32'd0);
    $display("txn %s addr=0x%08h be=%b rdata=0x%08h", v.name, v.addr, v.be, lsu_rdata_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //         name   we  size    addr   wdata   rdata  kind   be  wd_exp rd_exp
    vecs[0]  = '{"LW",  0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, K_OK, 4'b1111, 32'h0, 32'hDEADBEEF};
    vecs[1]  = '{"LB",  0, 3'b000, 32'h203, 32'h0, 32'h80112233, K_OK, 4'b1000, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{"LBU", 0, 3'b100, 32'h203, 32'h0, 32'h80112233, K_OK, 4'b1000, 32'h0, 32'h00000080};
    vecs[3]  = '{"LH",  0, 3'b001, 32'h202, 32'h0, 32'h80010000, K_OK, 4'b1100, 32'h0, 32'hFFFF8001};
    vecs[4]  = '{"LHU", 0, 3'b101, 32'h200, 32'h0, 32'h80017FFE, K_OK, 4'b0011, 32'h0, 32'h00007FFE};
    vecs[5]  = '{"LB1", 0, 3'b000, 32'h201, 32'h0, 32'h12345678, K_OK, 4'b0010, 32'h0, 32'h00000056};
    vecs[6]  = '{"SB",  1, 3'b000, 32'h001, 32'h000000A5, 32'h0, K_OK, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[7]  = '{"SH",  1, 3'b001, 32'h002, 32'h00001234, 32'h0, K_OK, 4'b1100, 32'h12341234, 32'h0};
    vecs[8]  = '{"SW",  1, 3'b010, 32'h00C, 32'hCAFEF00D, 32'h0, K_OK, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{"LWmis", 0, 3'b010, 32'h102, 32'h0, 32'h0, K_MIS, 4'b0, 32'h0, 32'h0};
    vecs[10] = '{"LHmis", 0, 3'b001, 32'h101, 32'h0, 32'h0, K_MIS, 4'b0, 32'h0, 32'h0};
    vecs[11] = '{"LHUmis", 0, 3'b101, 32'h103, 32'h0, 32'h0, K_MIS, 4'b0, 32'h0, 32'h0};
    vecs[12] = '{"SBUill", 1, 3'b100, 32'h000, 32'h0, 32'h0, K_ILL, 4'b0, 32'h0, 32'h0};

    idle_inputs();
    rst_i = 1;
    #1;
    chk("reset stall", {31'd0, lsu_stall_o}, 32'd0);
    chk("reset req", {31'd0, data_req_o}, 32'd0);
    chk("reset rdata", lsu_rdata_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // gnt held low for 5 cycles: bus fields must not move.
    start(0, 3'b010, 32'h300, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      chk("wait req", {31'd0, data_req_o}, 32'd1);
      chk("wait addr", data_addr_o, 32'h300);
      chk("wait be", {28'd0, data_be_o}, 32'hF);
      chk("wait stall", {31'd0, lsu_stall_o}, 32'd1);
    end
    data_gnt_i = 1;
    @(negedge clk_i); data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h0BADF00D;
    @(negedge clk_i); data_rvalid_i = 0; #1;
    chk("late gnt rdata", lsu_rdata_o, 32'h0BADF00D);
    last_rd = 32'h0BADF00D;
    lsu_req_i = 0;
    $display("txn LW late-gnt rdata=0x%08h", lsu_rdata_o);

    // Kill in the 3rd REQ cycle: back to IDLE, no DONE, rvalid ignored afterwards.
    start(0, 3'b001, 32'h020, 32'h0);
    @(negedge clk_i); #1;
    chk("kreq c1", {31'd0, data_req_o}, 32'd1);
    @(negedge clk_i); #1;
    chk("kreq c2", {31'd0, data_req_o}, 32'd1);
    @(negedge clk_i); lsu_kill_i = 1; #1;
    chk("kreq stall on kill", {31'd0, lsu_stall_o}, 32'd0);
    @(negedge clk_i); lsu_kill_i = 0; lsu_req_i = 0; data_rvalid_i = 1; data_rdata_i = 32'hFFFFFFFF; #1;
    chk("kreq req dropped", {31'd0, data_req_o}, 32'd0);
    chk("kreq stall idle", {31'd0, lsu_stall_o}, 32'd0);
    @(negedge clk_i); data_rvalid_i = 0; #1;
    chk("kreq rdata kept", lsu_rdata_o, last_rd);
    $display("txn LH killed in REQ");

    // Kill in RESP: response consumed but discarded.
    start(0, 3'b010, 32'h040, 32'h0);
    @(negedge clk_i); data_gnt_i = 1;
    @(negedge clk_i); data_gnt_i = 0; lsu_kill_i = 1; #1;
    chk("kresp stall on kill", {31'd0, lsu_stall_o}, 32'd0);
    @(negedge clk_i); lsu_kill_i = 0; lsu_req_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h55;
    @(negedge clk_i); data_rvalid_i = 0; #1;
    chk("kresp rdata kept", lsu_rdata_o, last_rd);
    chk("kresp stall idle", {31'd0, lsu_stall_o}, 32'd0);
    $display("txn LW killed in RESP");

    // gnt and kill together: discard flag set at grant.
    start(0, 3'b010, 32'h044, 32'h0);
    @(negedge clk_i); data_gnt_i = 1; lsu_kill_i = 1;
    @(negedge clk_i); data_gnt_i = 0; lsu_kill_i = 0; lsu_req_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h77;
    @(negedge clk_i); data_rvalid_i = 0; #1;
    chk("gntkill rdata kept", lsu_rdata_o, last_rd);
    $display("txn LW gnt+kill discarded");

    // The FSM must be back in IDLE with normal latency.
    run_vec(vecs[3]);

    // Asynchronous reset in REQ.
    start(1, 3'b010, 32'h0F0, 32'h89ABCDEF);
    @(negedge clk_i); #1;
    chk("prerst req", {31'd0, data_req_o}, 32'd1);
    rst_i = 1; #1;
    chk("rst req", {31'd0, data_req_o}, 32'd0);
    chk("rst be", {28'd0, data_be_o}, 32'd0);
    chk("rst addr", data_addr_o, 32'd0);
    chk("rst wdata", data_wdata_o, 32'd0);
    chk("rst we", {31'd0, data_we_o}, 32'd0);
    chk("rst stall", {31'd0, lsu_stall_o}, 32'd0);
    chk("rst rdata", lsu_rdata_o, 32'd0);
    last_rd = 32'd0;
    lsu_req_i = 0;
    @(negedge clk_i); rst_i = 0;
    $display("txn SW reset in REQ");

    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/miriscv_lsu.md
Name: miriscv_lsu

Overview:
- Load/store unit of the miriscv core; the responder to the decoder's memory request fields (mem_req, mem_we, mem_size = funct3).
- Takes one LOAD/STORE from the execute stage and runs a single-outstanding transaction on the data bus.
- Generates byte enables and store-data replication, and sign/zero-extends load data.
- Stalls the pipeline until the access completes; flags misaligned accesses without touching the bus.

Parameters:
- XLEN, 32, datapath and address width (only 32 supported).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous reset, active-high
- lsu_req_i  in  1  memory instruction in execute; held by the core while lsu_stall_o=1
- lsu_we_i  in  1  1=store, 0=load
- lsu_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr_i  in  XLEN  effective byte address
- lsu_wdata_i  in  XLEN  store data (rs2)
- lsu_kill_i  in  1  flush of the current instruction
- lsu_rdata_o  out  XLEN  extended load result; valid while state=DONE and held until the next load completes
- lsu_stall_o  out  1  pipeline stall
- lsu_misaligned_o  out  1  combinational misaligned flag for the current request
- data_req_o  out  1  bus request
- data_we_o  out  1  bus write
- data_be_o  out  4  byte enables
- data_addr_o  out  XLEN  word-aligned address
- data_wdata_o  out  XLEN  replicated store data
- data_gnt_i  in  1  bus grant (address phase accepted)
- data_rvalid_i  in  1  response valid (loads and stores)
- data_rdata_i  in  XLEN  read data

Behaviour:
- Reset: all outputs 0; state=IDLE. Reset mid-transaction drops it immediately and returns to IDLE.
- Legal sizes: 000, 001, 010, 100, 101 (100/101 loads only).
- Illegal size (011, 11x, or store with 1xx): no transaction; stall=0, misaligned=0. The decoder traps these.
- Misaligned: size H/HU with addr[0]=1, or size W with addr[1:0]≠00.
  - Drives lsu_misaligned_o=lsu_req_i in IDLE; no bus activity; stall=0.
- Accept condition in IDLE: lsu_req_i & legal & aligned & !lsu_kill_i. On accept, register the bus outputs and go to REQ.
- Bus output values:
  - data_addr_o = {addr[31:2],00}; data_we_o = lsu_we_i.
  - Byte enables: B/BU = 0001<<addr[1:0]; H/HU = 0011<<addr[1:0]; W = 1111.
  - Store data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
- FSM states:
  - IDLE -> REQ on accept.
  - REQ: data_req_o=1 and all bus outputs stable until data_gnt_i.
    - gnt -> RESP, data_req_o=0 next cycle.
    - lsu_kill_i & !gnt -> IDLE, data_req_o=0.
    - gnt and kill in the same cycle -> RESP with the discard flag set.
  - RESP: wait for data_rvalid_i.
    - Load, not discarded: on rvalid, register the extended data, then go to DONE.
    - Store, or discard flag set: go to DONE (no data update), or to IDLE if discarded.
    - lsu_kill_i in RESP sets the discard flag; the response is still awaited.
  - DONE: one cycle, then unconditionally IDLE. lsu_req_i is still high for the same instruction and must not re-trigger.
- Stall:
  - stall = 1 in IDLE on accept, in REQ, and in RESP.
  - stall = 0 in DONE and otherwise.
  - stall is never asserted while lsu_kill_i=1.
- Load extraction, with off = addr[1:0] registered at accept:
  - byte = rdata[8*off +: 8]; half = rdata[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- data_rvalid_i in IDLE/REQ/DONE is ignored.
- Minimum latency: accept at cycle 0, req in cycle 1, gnt in cycle 1, rvalid in cycle 2, DONE in cycle 3. Stall is high in cycles 0-2.

Test Plan:
- LW at addr 0x100, gnt on first request cycle, rvalid one cycle later with rdata=0xDEADBEEF -> data_addr_o=0x100, data_be_o=1111, stall high cycles 0-2, lsu_rdata_o=0xDEADBEEF in DONE (cycle 3).
- LB at addr 0x203, rdata=0x80112233 -> be=1000, lsu_rdata_o=0xFFFFFF80. Repeat with LBU -> 0x00000080. LH at 0x202, rdata=0x80010000 -> 0xFFFF8001.
- SB at 0x001 with wdata=0x000000A5 -> be=0010, data_wdata_o=0xA5A5A5A5, we=1. SH at 0x002 with wdata=0x1234 -> be=1100, wdata=0x12341234. lsu_rdata_o unchanged.
- LW at 0x102 and LH at 0x101 -> lsu_misaligned_o=1, stall=0, data_req_o never asserted.
- data_gnt_i held low 5 cycles -> data_req_o and bus fields stable for all 5, stall high. Kill in 3rd REQ cycle -> IDLE next cycle, req drops, no DONE.
- Kill in RESP on an LW, then rvalid=0x55 -> lsu_rdata_o keeps its prior value, FSM goes to IDLE. Assert rst_i in REQ -> all outputs 0 asynchronously.
